jtframe_clkmon: RTL and testbench
=================================

Name: jtframe_clkmon

Overview:
- Measures an asynchronous test clock against the system clock and reports its edge count per fixed window, a frequency-error classification and a debounced lock status.
- Counterpart to the frame's clock generators: it consumes and checks the clocks they produce (e.g. the 24 MHz and 6 MHz derived clocks) in simulation and on hardware, and drives status LEDs or OSD.

Parameters:
- WINDOW, 1024, clk cycles per measurement window (≥4).
- CW, 16, width of edge counter and count output.
- EXPECTED, 256, nominal tclk rising edges per window.
- TOL, 2, allowed ± deviation from EXPECTED, inclusive.
- NLOCK, 4, consecutive good windows required to assert locked (≥1).

Ports:
- clk  in  1  system clock; all logic in this domain.
- rst_n  in  1  asynchronous active-low reset.
- tclk  in  1  clock under test, asynchronous to clk.
- clr  in  1  synchronous restart: abort current window, clear streak, drop locked.
- count  out  CW  edge count of last completed window.
- count_vld  out  1  one-cycle pulse when count updates.
- slow  out  1  last window count < EXPECTED-TOL.
- fast  out  1  last window count > EXPECTED+TOL.
- dead  out  1  last window count == 0.
- locked  out  1  debounced in-tolerance status.
- lost  out  1  one-cycle pulse on locked 1→0 transition caused by a bad window.

Behaviour:
- Reset (rst_n low, async): count=0, count_vld=0, slow=0, fast=0, dead=0, locked=0, lost=0; sync chain, window counter, edge counter and streak counter = 0; FSM=UNLOCKED.
- Sync: tclk passes through a 2-flop synchronizer plus one history flop. Edge = sync_q & ~hist_q. Latency tclk rise → edge detect is 2–3 clk cycles.
- Window counter wcnt runs 0..WINDOW-1. The cycle with wcnt==WINDOW-1 is the window end (wend).
- Edge counter ecnt increments on each edge and saturates at 2^CW-1.
- On wend, an edge in that same cycle counts into the closing window. The latched value is ecnt plus that edge, saturated. ecnt then restarts at 0.
- On wend+1: count holds the latched value and count_vld=1 for exactly one cycle. slow, fast and dead update in the same cycle and hold until the next window end.
- Compare is done in CW+1 bits. The low bound is max(EXPECTED-TOL, 0). good = !slow && !fast. dead implies slow, unless the low bound is 0.
- FSM states:
  - UNLOCKED: good window → streak+1. Bad window → streak=0. On a good window where streak reaches NLOCK → LOCKED, locked=1 in the same cycle as count_vld.
  - LOCKED: good window → stay. Bad window → UNLOCKED, streak=0, locked=0, lost=1 for one cycle (aligned with count_vld).
- clr (synchronous, highest priority after reset): wcnt=0, ecnt=0, streak=0, FSM=UNLOCKED, locked=0. No count_vld and no lost pulse are generated. count, slow, fast and dead hold their values. Edges in the clr cycle are discarded.
- clr asserted in the wend cycle: clr wins and no result is produced.
- Async reset mid-window: immediate return to reset values. The first window after release is a full WINDOW cycles.
- A tclk frequency ≥ clk/2 is out of scope; counts alias low and the result is flagged slow.

Decomposition:
- Shared package jtframe_clkmon_pkg:
  - FSM state enum {UNLOCKED, LOCKED}.
  - Function computing the clipped low/high bounds in CW+1 bits.
- One sub-module: jtframe_clkmon_sync (2-flop synchronizer + rising-edge detector, async active-low reset), reusable by other CDC status inputs.

Test Plan:
- Nominal lock: clk 96 MHz, tclk 24 MHz, WINDOW=96, EXPECTED=24, TOL=1, NLOCK=4.
  - Each count_vld shows count=24, slow/fast/dead=0.
  - locked rises with the 4th count_vld; lost never pulses.
- Loss of clock: after lock, stop tclk.
  - At the first window with count=0: dead=1, slow=1, locked falls, lost=1 for one cycle; count_vld aligned.
- Tolerance edges: tclk giving 23, 25, then 22 edges (WINDOW=96).
  - 23 and 25 → good (streak advances).
  - 22 → slow=1, streak cleared, no lock.
- Fast clock: tclk 32 MHz → count=32, fast=1, locked stays 0.
- Boundary timing: place a synchronized edge exactly on the wend cycle.
  - It is counted in the closing window (count=24, not 23). The next window also reads 24, with no double count.
- clr and reset mid-window:
  - clr at wcnt=50 while locked → locked=0, no lost, no count_vld. Lock is re-acquired exactly NLOCK full windows later.
  - rst_n low at wcnt=30 → all outputs 0 immediately.

Source files
------------

// File: rtl/jtframe_clkmon_pkg.sv
// ============================================================================
// Module   : jtframe_clkmon_pkg
// Brief    : Shared types and bound helpers for the clock monitor
// Revision : 1.0
// ============================================================================
`default_nettype none

package jtframe_clkmon_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } clkmon_state_e;

  // Lower tolerance bound, floored at zero so a wide TOL never wraps negative
  function automatic longint clkmon_lo_bound(input longint expected, input longint tol);
    longint lo;
    lo = (expected > tol) ? (expected - tol) : longint'(0);
    return lo;
  endfunction

  // Upper tolerance bound, clipped to what fits in a CW+1 bit comparison
  function automatic longint clkmon_hi_bound(input longint expected, input longint tol,
                                             input int cw);
    longint lim;
    longint hi;
    lim = (longint'(1) <<< (cw + 1)) - longint'(1);
    hi  = expected + tol;
    return (hi > lim) ? lim : hi;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_clkmon_sync.sv
// ============================================================================
// Module   : jtframe_clkmon_sync
// Brief    : Two-flop synchronizer followed by a rising-edge detector
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtframe_clkmon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign rise = r_sync & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/jtframe_clkmon.sv
// ============================================================================
// Module   : jtframe_clkmon
// Brief    : Counts test-clock edges per window, classifies and debounces lock
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtframe_clkmon
  import jtframe_clkmon_pkg::*;
#(
  parameter int WINDOW   = 1024,
  parameter int CW       = 16,
  parameter int EXPECTED = 256,
  parameter int TOL      = 2,
  parameter int NLOCK    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tclk,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          count_vld,
  output logic          slow,
  output logic          fast,
  output logic          dead,
  output logic          locked,
  output logic          lost
);

  localparam int                c_ww       = $clog2(WINDOW);
  localparam logic [c_ww-1:0]   c_wlast    = c_ww'(WINDOW - 1);
  localparam int                c_sw       = $clog2(NLOCK + 1);
  localparam logic [c_sw-1:0]   c_nlock    = c_sw'(NLOCK);
  localparam logic [c_sw-1:0]   c_nlock_m1 = c_sw'(NLOCK - 1);
  localparam logic [CW:0]       c_lo       = (CW+1)'(clkmon_lo_bound(EXPECTED, TOL));
  localparam logic [CW:0]       c_hi       = (CW+1)'(clkmon_hi_bound(EXPECTED, TOL, CW));

  logic            w_rise;
  logic            w_wend;
  logic            w_ecnt_sat;
  logic [CW-1:0]   w_ecnt_nxt;
  logic [CW:0]     w_cmp;
  logic            w_slow;
  logic            w_fast;
  logic            w_dead;
  logic            w_good;

  logic [c_ww-1:0] r_wcnt;
  logic [CW-1:0]   r_ecnt;
  logic [CW-1:0]   r_count;
  logic            r_vld;
  logic            r_slow;
  logic            r_fast;
  logic            r_dead;

  clkmon_state_e   r_state;
  logic [c_sw-1:0] r_streak;
  logic            r_locked;
  logic            r_lost;

  jtframe_clkmon_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tclk),
    .rise  (w_rise)
  );

  // An edge landing on the window-end cycle belongs to the closing window
  assign w_wend     = (r_wcnt == c_wlast);
  assign w_ecnt_sat = &r_ecnt;
  assign w_ecnt_nxt = (w_rise && !w_ecnt_sat) ? (r_ecnt + CW'(1)) : r_ecnt;

  assign w_cmp  = {1'b0, w_ecnt_nxt};
  assign w_slow = (w_cmp < c_lo);
  assign w_fast = (w_cmp > c_hi);
  assign w_dead = (w_ecnt_nxt == '0);
  assign w_good = !w_slow && !w_fast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= '0;
      r_ecnt  <= '0;
      r_count <= '0;
      r_vld   <= 1'b0;
      r_slow  <= 1'b0;
      r_fast  <= 1'b0;
      r_dead  <= 1'b0;
    end else if (clr) begin
      // Results of the previous window stay visible across a restart
      r_wcnt  <= '0;
      r_ecnt  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_wend) begin
        r_wcnt  <= '0;
        r_ecnt  <= '0;
        r_count <= w_ecnt_nxt;
        r_vld   <= 1'b1;
        r_slow  <= w_slow;
        r_fast  <= w_fast;
        r_dead  <= w_dead;
      end else begin
        r_wcnt  <= r_wcnt + c_ww'(1);
        r_ecnt  <= w_ecnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= UNLOCKED;
      r_streak <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else if (clr) begin
      r_state  <= UNLOCKED;
      r_streak <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      if (w_wend) begin
        case (r_state)
          UNLOCKED: begin
            if (!w_good) begin
              r_streak <= '0;
            end else if (r_streak == c_nlock_m1) begin
              r_streak <= c_nlock;
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_streak <= r_streak + c_sw'(1);
            end
          end
          LOCKED: begin
            if (!w_good) begin
              r_state  <= UNLOCKED;
              r_streak <= '0;
              r_locked <= 1'b0;
              r_lost   <= 1'b1;
            end
          end
          default: begin
            r_state  <= UNLOCKED;
            r_streak <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count     = r_count;
  assign count_vld = r_vld;
  assign slow      = r_slow;
  assign fast      = r_fast;
  assign dead      = r_dead;
  assign locked    = r_locked;
  assign lost      = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_clkmon.sv
// ============================================================================
// Module   : tb_jtframe_clkmon
// Brief    : Directed, table-driven bench for the clock monitor
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jtframe_clkmon;

  localparam int WINDOW   = 96;
  localparam int CW       = 16;
  localparam int EXPECTED = 24;
  localparam int TOL      = 1;
  localparam int NLOCK    = 4;
  localparam int NVEC     = 19;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          tclk  = 1'b0;
  logic          clr   = 1'b0;
  logic [CW-1:0] count;
  logic          count_vld;
  logic          slow;
  logic          fast;
  logic          dead;
  logic          locked;
  logic          lost;

  int tests = 0;
  int fails = 0;

  jtframe_clkmon #(
    .WINDOW   (WINDOW),
    .CW       (CW),
    .EXPECTED (EXPECTED),
    .TOL      (TOL),
    .NLOCK    (NLOCK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tclk      (tclk),
    .clr       (clr),
    .count     (count),
    .count_vld (count_vld),
    .slow      (slow),
    .fast      (fast),
    .dead      (dead),
    .locked    (locked),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  // n pulses of tclk, period 3 clk cycles, starting at window cycle off
  typedef struct {
    int            n;
    int            off;
    logic [CW-1:0] cnt;
    logic          slw;
    logic          fst;
    logic          dd;
    logic          lck;
    logic          lst;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [21:0] snap();
    return {count_vld, count, slow, fast, dead, locked, lost};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pulse_at(input int k, input int n, input int off);
    return (k >= off) && (k < off + 3 * n) && (((k - off) % 3) == 0);
  endfunction

  // Entered and left on a negedge where the DUT window counter is 0
  task automatic run_window(input int n, input int off);
    logic spur;
    spur = 1'b0;
    for (int k = 0; k < WINDOW; k++) begin
      tclk = pulse_at(k, n, off);
      @(negedge clk);
      if (k < WINDOW - 1 && (count_vld || lost)) spur = 1'b1;
    end
    check("no_pulse_midwindow", 64'(spur), 64'(0));
  endtask

  task automatic expect_win(input string name, input logic [CW-1:0] c, input logic s,
                            input logic f, input logic d, input logic l, input logic ls);
    check(name, 64'(snap()), 64'({1'b1, c, s, f, d, l, ls}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic spur;

    vecs[0]  = '{24,  0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{24,  0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{24,  0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{24,  0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{24,  0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{ 0,  0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{ 0,  0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{23,  0, 16'd23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{25,  0, 16'd25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{22,  0, 16'd22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{23,  0, 16'd23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{25,  0, 16'd25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{24,  0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32,  0, 16'd32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32,  0, 16'd32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{24, 24, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{24, 24, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{24, 24, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{24, 24, 16'd24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_state", 64'(snap()), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_window(vecs[i].n, vecs[i].off);
      check($sformatf("vec%0d_n%0d", i, vecs[i].n), 64'(snap()),
            64'({1'b1, vecs[i].cnt, vecs[i].slw, vecs[i].fst, vecs[i].dd,
                 vecs[i].lck, vecs[i].lst}));
    end

    // clr at wcnt=50 while locked; pulse attributed to the clr cycle is dropped
    spur = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      tclk = (k <= 48) && ((k % 3) == 0);
      clr  = (k == 50);
      @(negedge clk);
      if (count_vld || lost) spur = 1'b1;
    end
    clr = 1'b0;
    check("clr_no_pulse", 64'(spur), 64'(0));
    check("clr_state", 64'(snap()), 64'({1'b0, 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));

    run_window(24, 24);
    expect_win("relock_w1", 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window(24, 24);
    expect_win("relock_w2", 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window(24, 24);
    expect_win("relock_w3", 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window(24, 24);
    expect_win("relock_w4", 16'd24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset mid-window at wcnt=30
    for (int k = 0; k < 30; k++) begin
      tclk = (k % 3) == 0;
      @(negedge clk);
    end
    tclk  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'(snap()), 64'(0));
    repeat (3) @(negedge clk);
    check("reset_hold", 64'(snap()), 64'(0));
    rst_n = 1'b1;

    run_window(24, 24);
    expect_win("post_reset_w1", 16'd24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
